miim_master: RTL and testbench
==============================

Name: miim_master

Overview:
MDIO/MIIM management master. It sits directly downstream of the PHY configuration sequencer and accepts one-cycle write/read requests (PHY address, register address, write data). It serialises each request into an IEEE 802.3 Clause 22 management frame on MDC/MDIO, and returns read data with a valid pulse. The tristate MDIO pad buffer is instantiated at top level from mdio_o/mdio_oe/mdio_i.

Parameters:
CLK_DIV, 25, MDC half-period in clk cycles; one MDIO bit period is 2*CLK_DIV clk cycles; legal range 2..255.

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
miim_phyad  input  5  target PHY address, sampled with request
miim_regad  input  5  target register address, sampled with request
miim_wrdata  input  16  write data, sampled with request
miim_wren  input  1  write request strobe, one-cycle pulse
miim_rden  input  1  read request strobe, one-cycle pulse
busy  output  1  frame in progress; requests ignored while high
miim_rddata  output  16  last read data; held until next read completes
miim_rddata_valid  output  1  one-cycle pulse when miim_rddata updates
mdc  output  1  management clock
mdio_o  output  1  MDIO output value
mdio_oe  output  1  MDIO output enable, 1 = master drives
mdio_i  input  1  MDIO pad input

Behaviour:
- Reset: rstn is asynchronous and active-low; clock is clk. Reset drives busy=0, mdc=0, mdio_o=1, mdio_oe=0, miim_rddata=0, miim_rddata_valid=0, FSM=S_IDLE, all counters 0.
- Reset mid-frame aborts immediately. No partial read data is delivered.
- FSM states: S_IDLE, S_SHIFT, S_DONE.
- S_IDLE:
  - mdc=0, mdio_oe=0.
  - On a clk edge with miim_wren|miim_rden=1: latch phyad/regad/wrdata and op, then go to S_SHIFT.
  - busy is registered high on that same edge, so it is visible the cycle after the strobe.
  - If miim_wren and miim_rden are both high, the request is a write. The read is dropped.
- Frame: 64 bits, MSB first, bit index 0..63.
  - 32 preamble ones.
  - ST=01.
  - OP: 01 write, 10 read.
  - PHYAD[4:0], then REGAD[4:0].
  - TA: write drives 10; read releases the bus.
  - DATA[15:0].
- Bit timing:
  - Each bit period is CLK_DIV cycles with mdc=0, then CLK_DIV cycles with mdc=1.
  - mdio_o/mdio_oe update on the cycle mdc goes low, i.e. at bit start.
  - Half-period counter runs 0..CLK_DIV-1. Bit counter is 6 bits.
- Output enable:
  - Write: mdio_oe=1 for all 64 bits.
  - Read: mdio_oe=1 for bits 0..45 and 0 for bits 46..63 (TA + data). mdio_o=1 while released.
- Read sampling:
  - mdio_i is sampled on the clk cycle where mdc goes 0->1 in bits 48..63.
  - Samples shift into a 16-bit register, MSB first.
  - No synchroniser inside the block; the top level provides a 2-flop synchroniser on mdio_i.
- Frame end: after the high phase of bit 63, go to S_DONE.
- S_DONE (one cycle):
  - mdc=0, mdio_oe=0, busy=0 from the next cycle.
  - Read only: miim_rddata updated and miim_rddata_valid=1 for exactly one cycle.
  - Then return to S_IDLE.
- busy duration: exactly 128*CLK_DIV+1 cycles per frame.
- Minimum gap: the earliest next request is accepted in the cycle after busy falls.
- Strobes asserted while busy=1 are ignored (not queued). Input fields are ignored except on the accepting edge.

Test Plan:
- CLK_DIV=4, write phyad=0, regad=0, wrdata=0x0044 -> busy high 513 cycles. mdc has 64 periods of 8 clk each. Bitstream = 32x'1', 0101 00000 00000 10 0000000001000100. mdio_oe=1 throughout. No rddata_valid.
- CLK_DIV=4, read phyad=0, regad=2. PHY model drives 0x0283 MSB-first from the rising edge of bit 47 -> mdio_oe falls at bit 46 start. miim_rddata=0x0283 with a single-cycle rddata_valid coincident with busy falling.
- Request during busy: second wren pulse 100 cycles into a write -> ignored. Exactly one frame is emitted; busy never re-rises without a new strobe after it falls.
- Simultaneous miim_wren=miim_rden=1 with regad=0, wrdata=0x1234 -> OP bits = 01, write frame only, no rddata_valid.
- Back-to-back: read (0x0283) then write issued on the first idle cycle after busy falls -> second frame starts, no lost cycle, preamble intact.
- rstn pulsed low during bit 50 of a read -> mdc=0, mdio_oe=0, busy=0 immediately. rddata stays 0, no valid pulse. A new read after reset completes correctly.

Source files
------------

// File: rtl/miim_if.sv
// Request/response bundle between the PHY config sequencer and miim_master.
interface miim_if;
  logic [4:0]  miim_phyad;
  logic [4:0]  miim_regad;
  logic [15:0] miim_wrdata;
  logic        miim_wren;
  logic        miim_rden;
  logic        busy;
  logic [15:0] miim_rddata;
  logic        miim_rddata_valid;

  modport master (
    output miim_phyad, miim_regad, miim_wrdata,
    output miim_wren, miim_rden,
    input  busy, miim_rddata, miim_rddata_valid
  );

  modport slave (
    input  miim_phyad, miim_regad, miim_wrdata,
    input  miim_wren, miim_rden,
    output busy, miim_rddata, miim_rddata_valid
  );
endinterface

// File: rtl/miim_master.sv
// Clause 22 MDIO management master: serialises one
// 64-bit frame per request on MDC/MDIO.
module miim_master #(
  parameter int unsigned CLK_DIV = 25
) (
  input  logic  clk,
  input  logic  rstn,
  miim_if.slave miim,
  output logic  mdc,
  output logic  mdio_o,
  output logic  mdio_oe,
  input  logic  mdio_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [7:0] HMAX = 8'(CLK_DIV - 1);

  state_t      state, state_nxt;
  logic [7:0]  half_cnt;
  logic [5:0]  bit_cnt;
  logic [62:0] sh;
  logic [15:0] rd_sh;
  logic        is_wr;
  logic        req_go;
  logic        half_end;
  logic        last;
  logic [63:0] frame;

  assign req_go   = miim.miim_wren | miim.miim_rden;
  assign half_end = (half_cnt == HMAX);
  assign last     = half_end & mdc & (bit_cnt == 6'd63);

  // Released read bits are loaded as ones so mdio_o idles high.
  always_comb begin
    frame = {32'hFFFF_FFFF, 2'b01,
             miim.miim_wren ? 2'b01 : 2'b10,
             miim.miim_phyad, miim.miim_regad,
             miim.miim_wren ? 2'b10 : 2'b11,
             miim.miim_wren ? miim.miim_wrdata : 16'hFFFF};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (req_go) state_nxt = S_SHIFT;
      S_SHIFT: if (last)   state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      miim.busy              <= 1'b0;
      miim.miim_rddata       <= 16'h0;
      miim.miim_rddata_valid <= 1'b0;
      mdc      <= 1'b0;
      mdio_o   <= 1'b1;
      mdio_oe  <= 1'b0;
      half_cnt <= 8'd0;
      bit_cnt  <= 6'd0;
      sh       <= '0;
      rd_sh    <= 16'h0;
      is_wr    <= 1'b0;
    end else begin
      miim.miim_rddata_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req_go) begin
            is_wr     <= miim.miim_wren;
            sh        <= frame[62:0];
            mdio_o    <= frame[63];
            mdio_oe   <= 1'b1;
            miim.busy <= 1'b1;
            mdc       <= 1'b0;
            half_cnt  <= 8'd0;
            bit_cnt   <= 6'd0;
          end
        end
        S_SHIFT: begin
          if (!half_end) begin
            half_cnt <= half_cnt + 8'd1;
          end else begin
            half_cnt <= 8'd0;
            mdc      <= ~mdc;
            if (!mdc) begin
              if (bit_cnt >= 6'd48)
                rd_sh <= {rd_sh[14:0], mdio_i};
            end else if (bit_cnt == 6'd63) begin
              mdio_o  <= 1'b1;
              mdio_oe <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
              sh      <= {sh[61:0], 1'b1};
              mdio_o  <= sh[62];
              mdio_oe <= is_wr | (bit_cnt < 6'd45);
            end
          end
        end
        S_DONE: begin
          miim.busy <= 1'b0;
          bit_cnt   <= 6'd0;
          if (!is_wr) begin
            miim.miim_rddata       <= rd_sh;
            miim.miim_rddata_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_miim_master.sv
// Randomised bench for miim_master with a cycle-level
// frame model and a simple MDIO PHY responder.
module tb_miim_master;
  localparam int D  = 4;
  localparam int NB = 128 * D;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic mdc, mdio_o, mdio_oe;
  logic mdio_i = 1'b1;

  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] last_rd = 16'h0;

  miim_if miim();

  miim_master #(.CLK_DIV(D)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .miim    (miim.slave),
    .mdc     (mdc),
    .mdio_o  (mdio_o),
    .mdio_oe (mdio_oe),
    .mdio_i  (mdio_i)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_check(int n);
    int err = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (miim.busy !== 1'b0 || miim.miim_rddata_valid !== 1'b0 ||
          mdc !== 1'b0 || mdio_oe !== 1'b0)
        err++;
    end
    chk("idle", 32'(err), 32'd0);
  endtask

  task automatic run_frame(
    input bit          wr,
    input bit          rd,
    input logic [4:0]  pa,
    input logic [4:0]  ra,
    input logic [15:0] wd,
    input logic [15:0] phy,
    input int          inject,
    input int          abort_bit
  );
    bit w;
    logic [63:0] fr;
    int err = 0;
    int vcnt = 0;
    int vcyc = 0;
    w  = wr;
    fr = {32'hFFFF_FFFF, 2'b01, w ? 2'b01 : 2'b10, pa, ra,
          w ? 2'b10 : 2'b00, w ? wd : 16'h0};
    miim.miim_phyad  = pa;
    miim.miim_regad  = ra;
    miim.miim_wrdata = wd;
    miim.miim_wren   = wr;
    miim.miim_rden   = rd;
    tick();
    miim.miim_wren   = 1'b0;
    miim.miim_rden   = 1'b0;
    miim.miim_phyad  = 5'($urandom);
    miim.miim_regad  = 5'($urandom);
    miim.miim_wrdata = 16'($urandom);
    for (int c = 1; c <= NB + 2; c++) begin
      int b, ph;
      logic e_mdc, e_oe, e_o;
      if (c == inject + 1) begin
        miim.miim_wren = 1'b0;
        miim.miim_rden = 1'b0;
      end
      if (c <= NB) begin
        b     = (c - 1) / (2 * D);
        ph    = (c - 1) % (2 * D);
        e_mdc = (ph >= D);
        e_oe  = w || (b < 46);
        e_o   = e_oe ? fr[63-b] : 1'b1;
        if (b == abort_bit && ph == D) begin
          chk("pre_abort_stream", 32'(err), 32'd0);
          rstn = 1'b0;
          #1;
          chk("abort_mdc", 32'(mdc), 32'd0);
          chk("abort_oe", 32'(mdio_oe), 32'd0);
          chk("abort_busy", 32'(miim.busy), 32'd0);
          chk("abort_valid", 32'(miim.miim_rddata_valid), 32'd0);
          chk("abort_rddata", 32'(miim.miim_rddata), 32'd0);
          last_rd = 16'h0;
          mdio_i  = 1'b1;
          #2;
          rstn = 1'b1;
          return;
        end
        if (mdc !== e_mdc || mdio_oe !== e_oe || mdio_o !== e_o ||
            miim.busy !== 1'b1)
          err++;
        if (ph == D && !w && b >= 47 && b < 63)
          mdio_i = phy[15-(b-47)];
        if (ph == D && b == 63)
          mdio_i = 1'b1;
      end else if (c == NB + 1) begin
        if (mdc !== 1'b0 || mdio_oe !== 1'b0 || mdio_o !== 1'b1 ||
            miim.busy !== 1'b1)
          err++;
      end else begin
        chk("busy_fall", 32'(miim.busy), 32'd0);
      end
      if (miim.miim_rddata_valid === 1'b1) begin
        vcnt++;
        vcyc = c;
      end
      if (c == inject) begin
        miim.miim_wren   = 1'b1;
        miim.miim_rden   = 1'b1;
        miim.miim_wrdata = ~wd;
      end
      if (c < NB + 2) tick();
    end
    chk("stream", 32'(err), 32'd0);
    chk("valid_cnt", 32'(vcnt), w ? 32'd0 : 32'd1);
    if (!w) begin
      chk("valid_cyc", 32'(vcyc), 32'(NB + 2));
      last_rd = phy;
    end
    chk("rddata", 32'(miim.miim_rddata), 32'(last_rd));
  endtask

  initial begin
    int op;
    miim.miim_phyad  = 5'h0;
    miim.miim_regad  = 5'h0;
    miim.miim_wrdata = 16'h0;
    miim.miim_wren   = 1'b0;
    miim.miim_rden   = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 32'(miim.busy), 32'd0);
    chk("rst_mdc", 32'(mdc), 32'd0);
    chk("rst_mdio_o", 32'(mdio_o), 32'd1);
    chk("rst_oe", 32'(mdio_oe), 32'd0);
    chk("rst_rddata", 32'(miim.miim_rddata), 32'd0);
    chk("rst_valid", 32'(miim.miim_rddata_valid), 32'd0);
    rstn = 1'b1;
    idle_check(3);

    run_frame(1'b1, 1'b0, 5'd0, 5'd0, 16'h0044, 16'h0, -1, -1);
    idle_check(10);
    run_frame(1'b0, 1'b1, 5'd0, 5'd2, 16'h0, 16'h0283, -1, -1);
    idle_check(10);
    run_frame(1'b1, 1'b0, 5'h11, 5'h04, 16'hBEEF, 16'h0, 100, -1);
    idle_check(20);
    run_frame(1'b1, 1'b1, 5'd0, 5'd0, 16'h1234, 16'h0, -1, -1);
    idle_check(5);
    run_frame(1'b0, 1'b1, 5'd0, 5'd2, 16'h0, 16'h0283, -1, -1);
    run_frame(1'b1, 1'b0, 5'h1F, 5'h1F, 16'hFFFF, 16'h0, -1, -1);
    idle_check(5);

    run_frame(1'b0, 1'b1, 5'd3, 5'd1, 16'h0, 16'hA5A5, -1, 50);
    idle_check(5);
    chk("post_abort_rddata", 32'(miim.miim_rddata), 32'd0);
    run_frame(1'b0, 1'b1, 5'd3, 5'd1, 16'h0, 16'h5A5A, -1, -1);
    idle_check(3);

    repeat (12) begin
      op = int'($urandom_range(0, 2));
      run_frame(op != 1, op != 0, 5'($urandom), 5'($urandom),
                16'($urandom), 16'($urandom), -1, -1);
      repeat ($urandom_range(0, 3)) tick();
    end
    idle_check(5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
